i2s_dac_tx: RTL and testbench



---
 rtl/i2s_dac_pkg.sv | 18 +
 rtl/i2s_dac_tx_if.sv | 32 +++
 rtl/sample_fifo.sv | 51 +++++
 rtl/i2s_dac_tx.sv | 130 +++++++++++++
 tb/tb_i2s_dac_tx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_dac_pkg.sv
// Shared types and constants for the I2S DAC transmitter.
// Slot format is chosen by I2S_DAC_TX_LJ_EN (see i2s_dac_tx).
package i2s_dac_pkg;

  localparam int DEF_DATA_W = 24;

  typedef enum logic [2:0] {
    SYNC,
    WAIT,
    DELAY,
    SHIFT,
    PAD
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Avalon-ST sample sinks (left and right) feeding the I2S DAC transmitter.
// master = sample source, slave = transmitter.
interface i2s_dac_tx_if #(
  parameter int DATA_W = 24
);

  logic [DATA_W-1:0] left_sink_data;
  logic              left_sink_valid;
  logic              left_sink_ready;
  logic [DATA_W-1:0] right_sink_data;
  logic              right_sink_valid;
  logic              right_sink_ready;

  modport master (
    output left_sink_data,
    output left_sink_valid,
    input  left_sink_ready,
    output right_sink_data,
    output right_sink_valid,
    input  right_sink_ready
  );

  modport slave (
    input  left_sink_data,
    input  left_sink_valid,
    output left_sink_ready,
    input  right_sink_data,
    input  right_sink_valid,
    output right_sink_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// Per-channel synchronous sample FIFO, no read bypass.
// Pointers wrap modulo FIFO_DEPTH (a power of two).
module sample_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: two sample FIFOs serialized onto dacdat.
// Define I2S_DAC_TX_LJ_EN for left-justified instead of standard I2S.
module i2s_dac_tx
  import i2s_dac_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  i2s_dac_tx_if.slave  sink,
  input  logic         bclk,
  input  logic         daclrck,
  output logic         dacdat,
  output logic         underflow_left,
  output logic         underflow_right
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic                   bclk_d_q;
  logic                   fe_q;
  logic                   lr_now_q;
  logic                   lr_prev_q;
  state_e                 st_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_W-1:0]      sh_q;

  logic              l_full, l_empty, l_ready, l_push, l_pop;
  logic              r_full, r_empty, r_ready, r_push, r_pop;
  logic [DATA_W-1:0] l_rdata, r_rdata, head;
  logic              slot_start, hit;

  // Two-flop pipeline after the synchronizer: fe and lr_now registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_d_q    <= 1'b0;
      fe_q        <= 1'b0;
      lr_now_q    <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], daclrck};
      bclk_d_q    <= bclk_sync_q[SYNC_STAGES-1];
      fe_q        <= bclk_d_q & ~bclk_sync_q[SYNC_STAGES-1];
      lr_now_q    <= lrck_sync_q[SYNC_STAGES-1];
    end
  end

  assign l_ready = ~l_full & ~reset;
  assign r_ready = ~r_full & ~reset;
  assign sink.left_sink_ready  = l_ready;
  assign sink.right_sink_ready = r_ready;
  assign l_push = sink.left_sink_valid & l_ready;
  assign r_push = sink.right_sink_valid & r_ready;

  assign slot_start = fe_q && (st_q != SYNC)
                      && (lr_now_q != lr_prev_q);
  assign hit  = (lr_now_q == LEFT) ? ~l_empty : ~r_empty;
  assign head = (lr_now_q == LEFT) ? l_rdata : r_rdata;
  assign l_pop = slot_start && (lr_now_q == LEFT) && ~l_empty;
  assign r_pop = slot_start && (lr_now_q == RIGHT) && ~r_empty;

  sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_l (
    .clk(clk), .reset(reset), .push(l_push), .pop(l_pop),
    .wdata(sink.left_sink_data), .rdata(l_rdata),
    .full(l_full), .empty(l_empty)
  );

  sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk(clk), .reset(reset), .push(r_push), .pop(r_pop),
    .wdata(sink.right_sink_data), .rdata(r_rdata),
    .full(r_full), .empty(r_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q            <= SYNC;
      lr_prev_q       <= 1'b0;
      cnt_q           <= '0;
      sh_q            <= '0;
      dacdat          <= 1'b0;
      underflow_left  <= 1'b0;
      underflow_right <= 1'b0;
    end else begin
      underflow_left  <= 1'b0;
      underflow_right <= 1'b0;
      if (fe_q) begin
        lr_prev_q <= lr_now_q;
        if (st_q == SYNC) begin
          st_q <= WAIT;
        end else if (slot_start) begin
          underflow_left  <= (lr_now_q == LEFT) & ~hit;
          underflow_right <= (lr_now_q == RIGHT) & ~hit;
`ifdef I2S_DAC_TX_LJ_EN
          dacdat <= hit & head[DATA_W-1];
          sh_q   <= hit ? {head[DATA_W-2:0], 1'b0} : '0;
          cnt_q  <= CW'(DATA_W - 1);
          st_q   <= SHIFT;
`else
          dacdat <= 1'b0;
          sh_q   <= hit ? head : '0;
          cnt_q  <= CW'(DATA_W);
          st_q   <= DELAY;
`endif
        end else begin
          case (st_q)
            DELAY, SHIFT: begin
              if (cnt_q == '0) begin
                dacdat <= 1'b0;
                st_q   <= PAD;
              end else begin
                dacdat <= sh_q[DATA_W-1];
                sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
                cnt_q  <= cnt_q - 1'b1;
                st_q   <= SHIFT;
              end
            end
            default: dacdat <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: bclk = clk/8, 32 BCLKs per slot.
// Honors I2S_DAC_TX_LJ_EN for the expected slot layout.
module tb_i2s_dac_tx;

  logic clk = 1'b0;
  logic reset;
  logic bclk;
  logic daclrck;
  logic dacdat;
  logic underflow_left;
  logic underflow_right;

  int total = 0;
  int bad = 0;
  int ul_cnt = 0;
  int ur_cnt = 0;
  int lpush_cnt = 0;

  i2s_dac_tx_if #(.DATA_W(24)) sif ();

  i2s_dac_tx #(.DATA_W(24), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .sink(sif),
    .bclk(bclk),
    .daclrck(daclrck),
    .dacdat(dacdat),
    .underflow_left(underflow_left),
    .underflow_right(underflow_right)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (underflow_left) ul_cnt++;
    if (underflow_right) ur_cnt++;
    if (sif.left_sink_valid && sif.left_sink_ready) lpush_cnt++;
  end

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        pl;
    logic        pr;
    int          ul;
    int          ur;
  } vec_t;

  vec_t vecs [5];

  // Bits seen on 32 bclk rises, first rise in bit 31.
  function automatic logic [31:0] fmt(input logic [23:0] w);
`ifdef I2S_DAC_TX_LJ_EN
    return {w, 8'h00};
`else
    return {1'b0, w, 7'h00};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One bclk period; optional left push timed to hit the slot-start pop cycle.
  task automatic bit_clk(input logic lr, input logic pl,
                         input logic [23:0] pw, output logic b);
    @(negedge clk);
    bclk = 1'b0;
    daclrck = lr;
    repeat (2) @(negedge clk);
    @(negedge clk);
    if (pl) begin
      sif.left_sink_data = pw;
      sif.left_sink_valid = 1'b1;
    end
    @(negedge clk);
    bclk = 1'b1;
    b = dacdat;
    if (pl) sif.left_sink_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_bits(input logic lr, input int n, input logic pl,
                          input logic [23:0] pw, output logic [31:0] bits);
    logic b;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bit_clk(lr, pl && (i == 0), pw, b);
      bits[31-i] = b;
    end
  endtask

  task automatic slot(input logic lr, output logic [31:0] bits);
    run_bits(lr, 32, 1'b0, 24'h0, bits);
  endtask

  task automatic push_l(input logic [23:0] w);
    sif.left_sink_data = w;
    sif.left_sink_valid = 1'b1;
    @(negedge clk);
    sif.left_sink_valid = 1'b0;
  endtask

  logic [31:0] bits;
  logic [23:0] words [5];
  int ul0, ur0, p0;

  initial begin
    vecs[0] = '{24'h800001, 24'h7FFFFE, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{24'h000000, 24'h000000, 1'b0, 1'b0, 1, 1};
    vecs[2] = '{24'hC00000, 24'h000000, 1'b1, 1'b1, 0, 0};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{24'h123ABC, 24'h000000, 1'b1, 1'b0, 0, 1};
    words[0] = 24'h111111;
    words[1] = 24'h222222;
    words[2] = 24'h333333;
    words[3] = 24'h444444;
    words[4] = 24'h555555;

    reset = 1'b1;
    bclk = 1'b1;
    daclrck = 1'b1;
    sif.left_sink_data = '0;
    sif.left_sink_valid = 1'b0;
    sif.right_sink_data = '0;
    sif.right_sink_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dacdat", {31'd0, dacdat}, 32'd0);
    check("rst_ul", {31'd0, underflow_left}, 32'd0);
    check("rst_ur", {31'd0, underflow_right}, 32'd0);
    check("rst_lrdy", {31'd0, sif.left_sink_ready}, 32'd0);
    check("rst_rrdy", {31'd0, sif.right_sink_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_lrdy", {31'd0, sif.left_sink_ready}, 32'd1);
    check("post_rrdy", {31'd0, sif.right_sink_ready}, 32'd1);

    // First edge only synchronizes: nothing sent, no underflow.
    ul0 = ul_cnt;
    ur0 = ur_cnt;
    slot(1'b1, bits);
    check("sync_bits", bits, 32'd0);
    check("sync_uf", ul_cnt + ur_cnt - ul0 - ur0, 0);

    for (int v = 0; v < 5; v++) begin
      sif.left_sink_data = vecs[v].l;
      sif.left_sink_valid = vecs[v].pl;
      sif.right_sink_data = vecs[v].r;
      sif.right_sink_valid = vecs[v].pr;
      @(negedge clk);
      sif.left_sink_valid = 1'b0;
      sif.right_sink_valid = 1'b0;
      ul0 = ul_cnt;
      ur0 = ur_cnt;
      slot(1'b0, bits);
      check($sformatf("vec%0d_l", v), bits,
            vecs[v].pl ? fmt(vecs[v].l) : 32'd0);
      slot(1'b1, bits);
      check($sformatf("vec%0d_r", v), bits,
            vecs[v].pr ? fmt(vecs[v].r) : 32'd0);
      check($sformatf("vec%0d_ul", v), ul_cnt - ul0, vecs[v].ul);
      check($sformatf("vec%0d_ur", v), ur_cnt - ur0, vecs[v].ur);
    end

    // Fill the left FIFO; the fifth word waits for the next pop.
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fill_rdy%0d", k),
            {31'd0, sif.left_sink_ready}, 32'd1);
      push_l(words[k]);
    end
    check("full_rdy", {31'd0, sif.left_sink_ready}, 32'd0);
    p0 = lpush_cnt;
    sif.left_sink_data = words[4];
    sif.left_sink_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_hold", lpush_cnt - p0, 0);
    slot(1'b0, bits);
    check("full_l0", bits, fmt(words[0]));
    check("full_push5", lpush_cnt - p0, 1);
    check("refull_rdy", {31'd0, sif.left_sink_ready}, 32'd0);
    sif.left_sink_valid = 1'b0;
    ur0 = ur_cnt;
    slot(1'b1, bits);
    for (int k = 1; k < 5; k++) begin
      slot(1'b0, bits);
      check($sformatf("drain_l%0d", k), bits, fmt(words[k]));
      slot(1'b1, bits);
    end
    check("drain_ur", ur_cnt - ur0, 5);

    // Push lands on the pop cycle of an empty FIFO: no bypass.
    ul0 = ul_cnt;
    p0 = lpush_cnt;
    run_bits(1'b0, 32, 1'b1, 24'h123456, bits);
    check("coinc_bits", bits, 32'd0);
    check("coinc_ul", ul_cnt - ul0, 1);
    check("coinc_push", lpush_cnt - p0, 1);
    slot(1'b1, bits);
    ul0 = ul_cnt;
    slot(1'b0, bits);
    check("coinc_next", bits, fmt(24'h123456));
    check("coinc_ul2", ul_cnt - ul0, 0);
    slot(1'b1, bits);

    // Reset in the middle of a left slot flushes both FIFOs.
    push_l(24'hABCDEF);
    push_l(24'h999999);
    run_bits(1'b0, 10, 1'b0, 24'h0, bits);
    check("mid_bits", bits, fmt(24'hABCDEF) & 32'hFFC0_0000);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_dacdat", {31'd0, dacdat}, 32'd0);
    check("mid_rst_rdy", {31'd0, sif.left_sink_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_rdy", {31'd0, sif.left_sink_ready}, 32'd1);
    ul0 = ul_cnt;
    ur0 = ur_cnt;
    run_bits(1'b0, 22, 1'b0, 24'h0, bits);
    check("mid_tail", bits, 32'd0);
    check("mid_no_uf", ul_cnt - ul0, 0);
    slot(1'b1, bits);
    check("mid_r", bits, 32'd0);
    check("mid_ur", ur_cnt - ur0, 1);
    push_l(24'hABCDEF);
    slot(1'b0, bits);
    check("mid_l_again", bits, fmt(24'hABCDEF));
    slot(1'b1, bits);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
